// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals behind the core's
// data-memory write bus.
//   tx_state_t        - UART transmitter frame states
//   DEFAULT_TX_ADDR   - store address that enqueues a console byte
//   DEFAULT_CTRL_ADDR - store address of the UART control word
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [31:0] DEFAULT_TX_ADDR   = 32'h0000_00FC;
    localparam logic [31:0] DEFAULT_CTRL_ADDR = 32'h0000_00F8;

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// byte_fifo: synchronous circular-buffer FIFO.
//   clk, rst   - clock, synchronous active-high reset (flushes the FIFO)
//   push, din  - write request and data; ignored while full
//   pop, dout  - read request and head data; dout shows the head
//                combinationally so the consumer can take it in the same
//                cycle it pops
//   full, empty, count - occupancy derived from the registered count
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    // Acceptance is judged on the registered count only: a pop in the same
    // cycle does not make room for a push into a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; stale entries are never visible because
    // the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers are exactly AW bits wide so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: console UART transmitter snooping the core's store bus.
//   clk, rst   - clock, synchronous active-high reset
//   data_addr  - processor data-memory address
//   write_data - processor store data (byte in [7:0], clear bit in [0])
//   we_mem     - processor store strobe
//   tx         - 8N1 serial output, idles high, driven from a register
//   busy       - FIFO non-empty or a frame in flight
//   fifo_full  - FIFO holds FIFO_DEPTH bytes
//   overflow   - sticky: a byte was dropped; cleared by a control store
// Stores to TX_ADDR are queued and never stall the core; a store that finds
// the FIFO full is dropped and flagged.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = mmio_pkg::DEFAULT_TX_ADDR,
    parameter logic [31:0] CTRL_ADDR    = mmio_pkg::DEFAULT_CTRL_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    input  logic        we_mem,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    import mmio_pkg::*;

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // Address decode
    logic push_req;
    logic clr_req;
    logic drop;

    // Upper store bits carry nothing for this peripheral.
    logic unused_write_hi;
    assign unused_write_hi = ^write_data[31:8];

    assign push_req = we_mem && (data_addr == TX_ADDR);
    assign clr_req  = we_mem && (data_addr == CTRL_ADDR) && write_data[0];

    // FIFO
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full_w;
    logic [AW:0]   fifo_count;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (write_data[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full_w),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign drop = push_req && fifo_full_w;

    // Overflow flag: a drop on the same edge as a clear wins.
    logic overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clr_req) begin
            overflow_reg <= 1'b0;
        end
    end

    // Transmit FSM
    tx_state_t         state_reg,  state_next;
    logic [BAUD_W-1:0] baud_reg,   baud_next;
    logic [2:0]        bit_reg,    bit_next;
    logic [7:0]        shift_reg,  shift_next;
    logic              tx_reg,     tx_next;
    logic              baud_last;

    assign baud_last = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                // Always pass through IDLE so back-to-back frames are
                // separated by one extra high cycle.
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The line level is registered from the state being entered, so tx
        // follows the FSM with no combinational path from the bus.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx        = tx_reg;
    assign busy      = (state_reg != IDLE) || (fifo_count != '0);
    assign fifo_full = fifo_full_w;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB + 1;
    localparam logic [31:0] A_TX   = 32'h0000_00FC;
    localparam logic [31:0] A_CTRL = 32'h0000_00F8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        we_mem = 1'b0;
    logic        tx, busy, fifo_full, overflow;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (A_TX),
        .CTRL_ADDR    (A_CTRL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_addr  (data_addr),
        .write_data (write_data),
        .we_mem     (we_mem),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic we);
        data_addr  = a;
        write_data = d;
        we_mem     = we;
        if (we || a == A_TX)
            $display("cycle %0d: store addr=%h data=%h we=%0d", cyc, a, d, we);
    endtask

    task automatic idle_bus();
        data_addr  = '0;
        write_data = '0;
        we_mem     = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input string tag);
        int n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        repeat (4) step();
    endtask

    // Serial decoder: samples the line in the middle of each bit.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         bad_stop = 0;

    initial begin
        int         t;
        logic [7:0] b;
        forever begin
            @(negedge tx);
            #1;
            t = cyc;
            repeat (CPB / 2) @(posedge clk);
            #1;
            if (tx !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1;
                b[i] = tx;
            end
            repeat (CPB) @(posedge clk);
            #1;
            if (tx !== 1'b1) bad_stop++;
            rx_q.push_back(b);
            rx_t.push_back(t);
            $display("cycle %0d: received byte %h", cyc, b);
        end
    end

    // Reference model of FIFO occupancy: each accepted byte is popped at the
    // later of one cycle after its store and one frame period after the
    // previous pop.
    int         m_push[$];
    int         m_pop[$];
    int         m_last_pop;
    logic       m_ovf;
    logic [7:0] exp_q[$];

    function automatic int count_at(input int c);
        int n = 0;
        foreach (m_push[i]) if (m_push[i] < c) n++;
        foreach (m_pop[i])  if (m_pop[i] < c) n--;
        return n;
    endfunction

    initial begin
        logic [7:0]  eb;
        logic [31:0] rd;
        logic        etx;
        int          r;
        int          k;
        int          p;
        int          cnt;

        idle_bus();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset_tx",   32'(tx),        32'd1);
        check("reset_busy", 32'(busy),      32'd0);
        check("reset_full", 32'(fifo_full), 32'd0);
        check("reset_ovf",  32'(overflow),  32'd0);
        repeat (2) step();

        // Single byte with full cycle-accurate line check.
        set_bus(A_TX, 32'hABCD_EF55, 1'b1);
        step();
        idle_bus();
        for (int c = 1; c <= 42; c++) begin
            eb = 8'h55;
            if (c < 2)        etx = 1'b1;
            else if (c <= 5)  etx = 1'b0;
            else if (c <= 37) etx = eb[(c - 6) / 4];
            else              etx = 1'b1;
            check($sformatf("single_tx_c%0d", c), 32'(tx), 32'(etx));
            check($sformatf("single_busy_c%0d", c), 32'(busy), 32'(c <= 41));
            if (c < 42) step();
        end
        repeat (4) step();
        check("single_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("single_rx_byte", 32'(rx_q[0]), 32'h55);
        rx_q.delete();
        rx_t.delete();

        // Address filter.
        set_bus(32'h0000_0054, 32'h0000_00FF, 1'b1); step();
        set_bus(A_CTRL,        32'h0000_00FE, 1'b1); step();
        set_bus(32'h0000_01FC, 32'h0000_0041, 1'b1); step();
        set_bus(A_TX,          32'h0000_0042, 1'b0); step();
        idle_bus();
        for (int c = 0; c < 100; c++) begin
            check("filter_line", {28'd0, tx, busy, fifo_full, overflow}, 32'b1000);
            step();
        end
        check("filter_rx_count", 32'(rx_q.size()), 32'd0);

        // Overflow: ten consecutive stores.
        for (int i = 0; i < 10; i++) begin
            set_bus(A_TX, 32'h0000_0030 + 32'(i), 1'b1);
            step();
            if (i == 7) check("ovf_full_e7", 32'(fifo_full), 32'd0);
            if (i == 8) begin
                check("ovf_full_e8", 32'(fifo_full), 32'd1);
                check("ovf_flag_e8", 32'(overflow),  32'd0);
            end
            if (i == 9) check("ovf_flag_e9", 32'(overflow), 32'd1);
        end
        idle_bus();
        step();
        set_bus(A_CTRL, 32'hFFFF_FFF0, 1'b1);
        step();
        idle_bus();
        check("ovf_clear_bit0_zero", 32'(overflow), 32'd1);
        set_bus(A_CTRL, 32'h0000_0001, 1'b1);
        step();
        idle_bus();
        check("ovf_clear", 32'(overflow), 32'd0);
        wait_drain(9 * FRAME + 100, "ovf_drain");
        check("ovf_rx_count", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            check($sformatf("ovf_rx_byte%0d", i), 32'(rx_q[i]), 32'h30 + 32'(i));
            if (i > 0)
                check($sformatf("ovf_period%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'(FRAME));
        end
        rx_q.delete();
        rx_t.delete();

        // Reset during data bit 3 of the first of four queued bytes.
        for (int i = 0; i < 4; i++) begin
            set_bus(A_TX, 32'h0000_00A0 + 32'(i), 1'b1);
            step();
        end
        idle_bus();
        repeat (15) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_tx",   32'(tx),        32'd1);
        check("rst_mid_busy", 32'(busy),      32'd0);
        check("rst_mid_full", 32'(fifo_full), 32'd0);
        check("rst_mid_ovf",  32'(overflow),  32'd0);
        for (int c = 0; c < 60; c++) begin
            check("rst_quiet", {30'd0, tx, busy}, 32'b10);
            step();
        end
        rx_q.delete();
        rx_t.delete();
        set_bus(A_TX, 32'h1234_565A, 1'b1);
        step();
        idle_bus();
        wait_drain(200, "rst_after_drain");
        check("rst_after_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("rst_after_byte", 32'(rx_q[0]), 32'h5A);
        rx_q.delete();
        rx_t.delete();

        // Continuous push/pop: one store per frame period.
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            rd = $urandom;
            exp_q.push_back(rd[7:0]);
            set_bus(A_TX, rd, 1'b1);
            step();
            idle_bus();
            check("cont_not_full", 32'(fifo_full), 32'd0);
            repeat (FRAME - 1) step();
        end
        wait_drain(200, "cont_drain");
        check("cont_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("cont_rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        rx_t.delete();

        // Randomized traffic against the occupancy model.
        exp_q.delete();
        m_push.delete();
        m_pop.delete();
        m_last_pop = -100000;
        m_ovf = 1'b0;
        for (int n = 0; n < 60; n++) begin
            k  = cyc;
            r  = $urandom_range(0, 9);
            rd = $urandom;
            if (r < 7) begin
                cnt = count_at(k);
                if (cnt < DEPTH) begin
                    p = (k + 1 > m_last_pop + FRAME) ? k + 1 : m_last_pop + FRAME;
                    m_push.push_back(k);
                    m_pop.push_back(p);
                    m_last_pop = p;
                    exp_q.push_back(rd[7:0]);
                end else begin
                    m_ovf = 1'b1;
                end
                set_bus(A_TX, rd, 1'b1);
            end else if (r == 7) begin
                if (rd[0]) m_ovf = 1'b0;
                set_bus(A_CTRL, rd, 1'b1);
            end else if (r == 8) begin
                set_bus(32'h0000_0100 + 32'($urandom_range(0, 255) * 4), rd, 1'b1);
            end else begin
                set_bus(A_TX, rd, 1'b0);
            end
            step();
            idle_bus();
            check($sformatf("rand_ovf%0d", n), 32'(overflow), 32'(m_ovf));
            check($sformatf("rand_full%0d", n), 32'(fifo_full), 32'(count_at(cyc) == DEPTH));
            repeat ($urandom_range(0, 12)) step();
        end
        wait_drain(2000, "rand_drain");
        check("rand_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("rand_rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        check("stop_bits", 32'(bad_stop), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
